dot_vec_loader: RTL and testbench
=================================

Name: dot_vec_loader

Overview:
- Producer side of the integer dot-product datapath.
- Accepts a narrow valid/ready stream of element pairs, `lanes` pairs per beat, and assembles full k-element operand vectors A and B.
- Presents the vectors, held stable under a valid/ready handshake, to the combinational dot-product unit.
- A fill buffer plus an output register allows a new vector to be gathered while the previous one is still held.

Parameters:
- bit_width, 8: signed element width of A and B.
- k, 32: elements per vector. Must be a multiple of lanes.
- lanes, 4: element pairs accepted per input beat.
- beats, k/lanes: derived, beats per vector. Not overridable.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  reset, asynchronous and active-low.
- i_valid  input  1  input beat valid.
- o_ready  output  1  loader can accept a beat.
- i_a  input  signed [bit_width-1:0] x lanes  A elements of this beat, lane 0 lowest index.
- i_b  input  signed [bit_width-1:0] x lanes  B elements of this beat.
- i_last  input  1  marks the final beat of a vector.
- o_valid  output  1  o_vec_a/o_vec_b hold a complete vector pair.
- i_ready  input  1  dot unit consumes the pair.
- o_vec_a  output  signed [bit_width-1:0] x k  assembled A vector.
- o_vec_b  output  signed [bit_width-1:0] x k  assembled B vector.
- o_err  output  1  sticky framing error.

Behaviour:
- Reset (i_rst_n low, asynchronous): o_valid=0, o_err=0, beat counter=0, fill_full=0, o_vec_a/o_vec_b all zero. o_ready=1 after reset releases. Reset mid-vector discards any partial data.
- Handshakes:
  - Input beat accepted when i_valid && o_ready.
  - Output pair consumed when o_valid && i_ready.
  - o_ready = !fill_full; purely a function of state, with no combinational path from i_valid or i_ready.
- Fill:
  - An accepted beat at counter c writes i_a[j] and i_b[j] to fill elements c*lanes+j, for j = 0..lanes-1.
  - The counter increments and wraps to 0 after beats-1.
  - Elements are stored exactly as received; no sign extension or arithmetic.
- Completion (accepted beat with c == beats-1):
  - If the output slot is free at that edge (o_valid==0, or o_valid && i_ready), the fill contents, including this beat, load into o_vec_a/o_vec_b and o_valid=1 on the next cycle. Latency is 1 cycle from final-beat acceptance to o_valid.
  - Otherwise fill_full=1 and o_ready drops.
- Pending transfer: while fill_full=1, the transfer to the output occurs on the edge where the pair is consumed. At that edge o_valid stays 1 with the new data and fill_full clears. o_ready=1 the following cycle.
- Output stability: while o_valid && !i_ready, o_vec_a/o_vec_b/o_valid do not change. o_valid falls only on consumption with no transfer pending.
- Simultaneous events: final-beat acceptance and consumption in the same cycle give a back-to-back transfer with no bubble. Sustained throughput is one vector per `beats` cycles.
- Framing:
  - i_last on a beat with c != beats-1: o_err set, the partial vector is discarded, the counter returns to 0, and no output is produced.
  - Final beat (c == beats-1) without i_last: o_err set, but the vector is still emitted.
  - o_err is sticky until reset.
- State: 2-state fill FSM.
  - FILLING: o_ready=1. Goes to FULL on completion with the slot busy.
  - FULL: o_ready=0. Returns to FILLING on consumption.
  - The output register has its own valid bit.

Test Plan (k=32, lanes=4, beats=8):
1. Reset, then 8 beats with i_a=lane index+4*beat (0..31), i_b=-(same), i_last on beat 7, i_ready=1 -> o_valid high one cycle after beat 7; o_vec_a[n]=n, o_vec_b[n]=-n; o_err=0.
2. i_ready=0, send two full vectors back-to-back -> first held stable; o_ready=0 after the 16th beat. Raise i_ready -> second vector appears the next cycle with no gap in o_valid; o_ready returns high.
3. Continuous streaming with i_ready=1 -> one o_valid pulse every 8 cycles; all elements correct across 4 vectors (first element of each vector is 127/-128 extremes, checked without corruption).
4. i_last on beat 3 -> o_err=1, no o_valid. Then a clean 8-beat vector -> emitted correctly; o_err stays 1.
5. Beat 7 without i_last -> vector emitted, o_err=1.
6. Assert i_rst_n low after 5 beats of a vector -> o_valid=0, o_err=0 immediately (asynchronous). A following clean vector is emitted with no stale elements.

Source files
------------

// File: rtl/dot_vec_loader.sv
`timescale 1ns/1ps
// Gathers lanes-wide element-pair beats into k-element A/B vectors and presents
// them to the dot-product unit under valid/ready, double-buffered (fill + output).
module dot_vec_loader #(
    parameter int bit_width = 8,
    parameter int k         = 32,
    parameter int lanes     = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_valid,
    output logic                              o_ready,
    input  logic [lanes-1:0][bit_width-1:0]   i_a,
    input  logic [lanes-1:0][bit_width-1:0]   i_b,
    input  logic                              i_last,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic [k-1:0][bit_width-1:0]       o_vec_a,
    output logic [k-1:0][bit_width-1:0]       o_vec_b,
    output logic                              o_err
);

    localparam int beats = k / lanes;
    localparam int cw    = (beats > 1) ? $clog2(beats) : 1;

    typedef enum logic {FILLING, FULL} state_t;

    state_t                       state_reg, state_next;
    logic [cw-1:0]                cnt_reg, cnt_next;
    logic [k-1:0][bit_width-1:0]  fill_a_reg, fill_b_reg;
    logic [k-1:0][bit_width-1:0]  fill_a_next, fill_b_next;
    logic [k-1:0][bit_width-1:0]  vec_a_reg, vec_b_reg;
    logic [k-1:0][bit_width-1:0]  vec_a_next, vec_b_next;
    logic                         valid_reg, valid_next;
    logic                         err_reg, err_next;

    logic accept, consume, last_beat, slot_free;

    assign o_ready   = (state_reg == FILLING);
    assign accept    = i_valid && o_ready;
    assign consume   = valid_reg && i_ready;
    assign last_beat = (cnt_reg == cw'(beats - 1));
    assign slot_free = !valid_reg || i_ready;

    // Fill buffer with the current beat merged in, so a completing beat can go
    // straight to the output register on the same edge.
    generate
        for (genvar gi = 0; gi < beats; gi++) begin : g_beat
            for (genvar gj = 0; gj < lanes; gj++) begin : g_lane
                assign fill_a_next[gi*lanes+gj] = (accept && cnt_reg == cw'(gi)) ?
                                                  i_a[gj] : fill_a_reg[gi*lanes+gj];
                assign fill_b_next[gi*lanes+gj] = (accept && cnt_reg == cw'(gi)) ?
                                                  i_b[gj] : fill_b_reg[gi*lanes+gj];
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        vec_a_next = vec_a_reg;
        vec_b_next = vec_b_reg;
        valid_next = valid_reg;
        err_next   = err_reg;

        // A mismatch between i_last and the final beat position is a framing error.
        if (accept) begin
            if (last_beat || i_last) begin
                cnt_next = '0;
            end else begin
                cnt_next = cnt_reg + cw'(1);
            end
            if (last_beat != i_last) begin
                err_next = 1'b1;
            end
        end

        case (state_reg)
            FILLING: begin
                if (accept && last_beat) begin
                    if (slot_free) begin
                        vec_a_next = fill_a_next;
                        vec_b_next = fill_b_next;
                        valid_next = 1'b1;
                    end else begin
                        state_next = FULL;
                    end
                end else if (consume) begin
                    valid_next = 1'b0;
                end
            end
            FULL: begin
                // Complete vector waits in the fill buffer until the held pair is taken.
                if (consume) begin
                    vec_a_next = fill_a_reg;
                    vec_b_next = fill_b_reg;
                    valid_next = 1'b1;
                    state_next = FILLING;
                end
            end
            default: state_next = FILLING;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg  <= FILLING;
            cnt_reg    <= '0;
            fill_a_reg <= '0;
            fill_b_reg <= '0;
            vec_a_reg  <= '0;
            vec_b_reg  <= '0;
            valid_reg  <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            fill_a_reg <= fill_a_next;
            fill_b_reg <= fill_b_next;
            vec_a_reg  <= vec_a_next;
            vec_b_reg  <= vec_b_next;
            valid_reg  <= valid_next;
            err_reg    <= err_next;
        end
    end

    assign o_valid = valid_reg;
    assign o_vec_a = vec_a_reg;
    assign o_vec_b = vec_b_reg;
    assign o_err   = err_reg;

endmodule

// File: tb/tb_dot_vec_loader.sv
`timescale 1ns/1ps
// Bench for dot_vec_loader: a two-deep queue model of completed vectors checked
// every cycle, plus directed vectors with hand-computed literal expectations.
module tb_dot_vec_loader;

    localparam int BW = 8;
    localparam int K  = 32;
    localparam int L  = 4;
    localparam int NB = K / L;

    typedef logic [K-1:0][BW-1:0] vec_t;

    logic                  i_clk = 1'b0;
    logic                  i_rst_n = 1'b0;
    logic                  i_valid = 1'b0;
    logic                  o_ready;
    logic [L-1:0][BW-1:0]  i_a = '0;
    logic [L-1:0][BW-1:0]  i_b = '0;
    logic                  i_last = 1'b0;
    logic                  o_valid;
    logic                  i_ready = 1'b0;
    vec_t                  o_vec_a, o_vec_b;
    logic                  o_err;

    dot_vec_loader #(.bit_width(BW), .k(K), .lanes(L)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_a(i_a), .i_b(i_b), .i_last(i_last), .o_valid(o_valid),
        .i_ready(i_ready), .o_vec_a(o_vec_a), .o_vec_b(o_vec_b), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int pops   = 0;

    task automatic chk(input string name, input logic [K*BW-1:0] act, input logic [K*BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of completed, unconsumed vectors (head is on the output,
    // a second entry is the complete fill buffer). Capacity two.
    vec_t qa[$];
    vec_t qb[$];
    vec_t cur_a, cur_b;
    int   pcnt  = 0;
    logic err_m = 1'b0;

    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            qa.delete();
            qb.delete();
            pcnt  = 0;
            err_m = 1'b0;
        end else begin
            bit ready_m;
            ready_m = (qa.size() < 2);
            chk("o_valid", o_valid, qa.size() != 0);
            chk("o_ready", o_ready, ready_m);
            chk("o_err", o_err, err_m);
            if (qa.size() != 0) begin
                chk("o_vec_a", o_vec_a, qa[0]);
                chk("o_vec_b", o_vec_b, qb[0]);
            end
            if (qa.size() != 0 && i_ready) begin
                void'(qa.pop_front());
                void'(qb.pop_front());
                pops++;
            end
            if (i_valid && ready_m) begin
                for (int j = 0; j < L; j++) begin
                    cur_a[pcnt*L+j] = i_a[j];
                    cur_b[pcnt*L+j] = i_b[j];
                end
                if (pcnt == NB - 1) begin
                    if (!i_last) err_m = 1'b1;
                    qa.push_back(cur_a);
                    qb.push_back(cur_b);
                    pcnt = 0;
                end else if (i_last) begin
                    err_m = 1'b1;
                    pcnt  = 0;
                end else begin
                    pcnt++;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send_beat(input logic [L-1:0][BW-1:0] a, input logic [L-1:0][BW-1:0] b,
                             input logic last);
        bit acc;
        i_valid = 1'b1;
        i_a     = a;
        i_b     = b;
        i_last  = last;
        for (int t = 0; t < 200; t++) begin
            @(negedge i_clk);
            acc = o_ready;
            @(posedge i_clk);
            #1;
            if (acc) return;
        end
        checks++;
        errors++;
        $display("FAIL beat_accept: got no acceptance expected acceptance within 200 cycles");
    endtask

    task automatic send_vec(input vec_t va, input vec_t vb, input int nbeats, input int last_at);
        logic [L-1:0][BW-1:0] ba, bb;
        for (int bt = 0; bt < nbeats; bt++) begin
            for (int j = 0; j < L; j++) begin
                ba[j] = va[bt*L+j];
                bb[j] = vb[bt*L+j];
            end
            send_beat(ba, bb, bt == last_at);
        end
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        i_last  = 1'b0;
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_last  = 1'b0;
        #1;
        chk("rst_o_valid", o_valid, 1'b0);
        chk("rst_o_err", o_err, 1'b0);
        chk("rst_o_vec_a", o_vec_a, '0);
        chk("rst_o_vec_b", o_vec_b, '0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        #1;
        chk("rst_o_ready", o_ready, 1'b1);
    endtask

    function automatic vec_t mk(input int mul, input int off);
        vec_t v;
        for (int n = 0; n < K; n++) v[n] = BW'(n * mul + off);
        return v;
    endfunction

    function automatic vec_t neg(input vec_t v);
        vec_t r;
        for (int n = 0; n < K; n++) r[n] = -v[n];
        return r;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t va, vb, v1a, v1b, v2a, v2b;
        logic [BW-1:0] e;
        int p0;

        @(posedge i_clk);
        #1;
        do_reset();

        // 1: ramp vector, latency one cycle from final beat
        i_ready = 1'b1;
        va = mk(1, 0);
        vb = neg(va);
        send_vec(va, vb, NB, NB - 1);
        chk("t1_valid_latency", o_valid, 1'b1);
        e = o_vec_a[5];
        chk("t1_a5", e, 8'd5);
        e = o_vec_b[31];
        chk("t1_b31", e, 8'hE1);
        chk("t1_err", o_err, 1'b0);
        idle(2);

        // 2: output held, second vector waits in fill buffer
        i_ready = 1'b0;
        v1a = mk(3, 1);  v1b = mk(5, 7);
        v2a = mk(7, 2);  v2b = mk(11, 9);
        send_vec(v1a, v1b, NB, NB - 1);
        send_vec(v2a, v2b, NB, NB - 1);
        idle(3);
        chk("t2_ready_low", o_ready, 1'b0);
        chk("t2_hold_a", o_vec_a, v1a);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        chk("t2_no_gap", o_valid, 1'b1);
        chk("t2_second_a", o_vec_a, v2a);
        chk("t2_ready_back", o_ready, 1'b1);
        idle(2);

        // 3: streaming, extremes in element 0
        p0 = pops;
        for (int v = 0; v < 4; v++) begin
            va = mk(v + 2, v * 13);
            vb = mk(v + 5, v * 29 + 3);
            va[0] = (v % 2 == 0) ? 8'h7F : 8'h80;
            vb[0] = (v % 2 == 0) ? 8'h80 : 8'h7F;
            send_vec(va, vb, NB, NB - 1);
            if (v == 0) begin
                e = o_vec_a[0];
                chk("t3_a0_max", e, 8'h7F);
                e = o_vec_b[0];
                chk("t3_b0_min", e, 8'h80);
            end
        end
        idle(3);
        chk("t3_pulses", 32'(pops - p0), 32'd4);

        // 4: early i_last discards partial vector
        va = mk(9, 4);
        send_vec(va, va, 4, 3);
        idle(3);
        chk("t4_err", o_err, 1'b1);
        chk("t4_no_valid", o_valid, 1'b0);
        va = mk(1, 40);
        vb = mk(2, 80);
        send_vec(va, vb, NB, NB - 1);
        chk("t4_emitted", o_vec_a, va);
        chk("t4_err_sticky", o_err, 1'b1);
        idle(2);
        do_reset();

        // 5: missing i_last on final beat still emits
        i_ready = 1'b1;
        va = mk(4, 6);
        vb = mk(6, 4);
        send_vec(va, vb, NB, -1);
        chk("t5_valid", o_valid, 1'b1);
        chk("t5_vec_b", o_vec_b, vb);
        chk("t5_err", o_err, 1'b1);
        idle(2);

        // 6: asynchronous reset mid-vector with a pair held on the output
        i_ready = 1'b0;
        send_vec(mk(5, 5), mk(3, 3), NB, NB - 1);
        send_vec(mk(8, 1), mk(2, 2), 5, -1);
        chk("t6_pre_valid", o_valid, 1'b1);
        do_reset();
        i_ready = 1'b1;
        va = mk(13, 17);
        vb = mk(19, 23);
        send_vec(va, vb, NB, NB - 1);
        chk("t6_clean_a", o_vec_a, va);
        chk("t6_clean_err", o_err, 1'b0);
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
